// File: rtl/mmio_port_arbiter_pkg.sv
// Shared ids, FSM encoding and read-return tag for the mmio port arbiter.
// Pure types and constants: no latency, no flow control.
package mmio_arb_pkg;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

    function automatic arb_state_e own_state(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mmio_port_arbiter_if.sv
// One requester's view of the shared mmio port: request/grant plus read return.
// gnt is combinational from req; rvalid follows a granted read by the mmio read latency.
interface mmio_port_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wren;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wren, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wren, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mmio_rd_return_pipe.sv
// Delays {valid,id} of each issued read by RD_LAT clocks to steer rvalid to the issuer.
// Latency RD_LAT (clamped to 1..RD_LAT_MAX); no backpressure, one tag accepted per clock.
module mmio_rd_return_pipe
    import mmio_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rd_vld_i,
    input  logic       rd_id_i,
    output logic [1:0] rvalid_o
);

    localparam int unsigned DEPTH = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                                    ((RD_LAT < 1) ? 1 : RD_LAT);

    rd_tag_t [DEPTH-1:0] pipe_q;
    rd_tag_t [DEPTH-1:0] pipe_d;
    rd_tag_t             tail;

    always_comb begin
        pipe_d        = pipe_q;
        pipe_d[0].vld = rd_vld_i;
        pipe_d[0].id  = rd_id_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Clearing the pipe on reset is what discards reads still in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail        = pipe_q[DEPTH-1];
    assign rvalid_o[0] = tail.vld && (tail.id == M0);
    assign rvalid_o[1] = tail.vld && (tail.id == M1);

endmodule

// File: rtl/mmio_port_arbiter.sv
// Round-robin arbiter sharing one mmio port between M0 and M1, with bounded burst lock; MMIO_ARB_STATS_EN adds grant counters.
// Grant and bus mux combinational, read data returns after RD_LAT; losers hold req until granted.
module mmio_port_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 8
`ifdef MMIO_ARB_STATS_EN
    ,
    parameter int unsigned STAT_W    = 16
`endif
) (
    input  logic                 clock,
    input  logic                 reset_btn,
    mmio_port_arbiter_if.slave   m0,
    mmio_port_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]    address_dmem,
    output logic [DATA_W-1:0]    data,
    output logic                 wren,
    input  logic [DATA_W-1:0]    q_dmem
`ifdef MMIO_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]    m0_grants,
    output logic [STAT_W-1:0]    m1_grants
`endif
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       lock_q, lock_d;
    logic [7:0] burst_q, burst_d;

    logic       gnt0, gnt1, xfer, gid, g_lock;
    logic       owner_vld, owner_id, same_owner, burst_full;
    logic [1:0] rvalid;

    assign owner_vld  = (state_q != IDLE);
    assign owner_id   = (state_q == OWN1);
    assign burst_full = (burst_q >= BURST_MAX);

    // A locked owner keeps a contested grant only until its burst budget runs out.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_btn) begin
            case ({m1.req, m0.req})
                2'b01:   gnt0 = 1'b1;
                2'b10:   gnt1 = 1'b1;
                2'b11: begin
                    if (owner_vld && lock_q && !burst_full) begin
                        gnt0 = (owner_id == M0);
                        gnt1 = (owner_id == M1);
                    end else begin
                        gnt0 = (last_q == M1);
                        gnt1 = (last_q == M0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign xfer       = gnt0 | gnt1;
    assign gid        = gnt1;
    assign g_lock     = gnt1 ? m1.lock : m0.lock;
    assign same_owner = owner_vld && (owner_id == gid);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        lock_d  = lock_q;
        burst_d = burst_q;
        if (!xfer) begin
            state_d = IDLE;
            lock_d  = 1'b0;
            burst_d = '0;
        end else begin
            state_d = own_state(gid);
            last_d  = gid;
            lock_d  = g_lock;
            if (!g_lock) begin
                burst_d = '0;
            end else if (same_owner && lock_q) begin
                // Exhausted budget with no contender: the owner starts a fresh count.
                burst_d = burst_full ? 8'd0 : burst_q + 8'd1;
            end else begin
                burst_d = 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            state_q <= IDLE;
            last_q  <= M1;
            lock_q  <= 1'b0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        if (gnt0) begin
            address_dmem = m0.addr;
            data         = m0.wdata;
            wren         = m0.wren;
        end else if (gnt1) begin
            address_dmem = m1.addr;
            data         = m1.wdata;
            wren         = m1.wren;
        end
    end

    assign m0.gnt   = gnt0;
    assign m1.gnt   = gnt1;
    assign m0.rdata = q_dmem;
    assign m1.rdata = q_dmem;

    mmio_rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i    (clock),
        .rst_ni   (reset_btn),
        .rd_vld_i (xfer && !wren),
        .rd_id_i  (gid),
        .rvalid_o (rvalid)
    );

    assign m0.rvalid = rvalid[0];
    assign m1.rvalid = rvalid[1];

`ifdef MMIO_ARB_STATS_EN
    logic [STAT_W-1:0] m0_grants_q, m0_grants_d;
    logic [STAT_W-1:0] m1_grants_q, m1_grants_d;

    always_comb begin
        m0_grants_d = m0_grants_q;
        m1_grants_d = m1_grants_q;
        if (gnt0 && (m0_grants_q != {STAT_W{1'b1}})) begin
            m0_grants_d = m0_grants_q + 1'b1;
        end
        if (gnt1 && (m1_grants_q != {STAT_W{1'b1}})) begin
            m1_grants_d = m1_grants_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            m0_grants_q <= '0;
            m1_grants_q <= '0;
        end else begin
            m0_grants_q <= m0_grants_d;
            m1_grants_q <= m1_grants_d;
        end
    end

    assign m0_grants = m0_grants_q;
    assign m1_grants = m1_grants_q;
`endif

endmodule
